vga_write_arbiter: RTL and testbench
====================================

# vga_write_arbiter

Round-robin arbiter sharing the single VGA adapter pixel-write port between three drawing engines: grid/background painter (requester 0), note/song renderer (requester 1), and hit-feedback flash renderer (requester 2). Grants whole bursts, bounded by a maximum burst length so no engine starves the others. Sits between the display FSM datapaths and the VGA adapter. Registers the selected pixel onto the adapter's x/y/colour/plot inputs.

## Interface
Parameters:
- X_W, 8, pixel x width (160-wide screen)
- Y_W, 7, pixel y width (120-tall screen)
- C_W, 3, colour width
- BURST_W, 8, burst counter width
- MAX_BURST, 160, maximum pixels per grant (1..2^BURST_W-1)

Ports:
- clock  in  1  system clock; only clock
- reset  in  1  synchronous, active-high
- req  in  3  per-requester write request; bit i = requester i
- last  in  3  bit i marks requester i's current pixel as the final pixel of its burst
- x_in  in  3*X_W  requester i's x at bits [i*X_W +: X_W]
- y_in  in  3*Y_W  packed as x_in
- colour_in  in  3*C_W  packed as x_in
- gnt  out  3  registered one-hot grant; all zero when idle
- vga_x  out  X_W  registered pixel x to adapter
- vga_y  out  Y_W  registered pixel y
- vga_colour  out  C_W  registered pixel colour
- vga_plot  out  1  registered write strobe, one cycle per accepted pixel
- busy  out  1  high while in GRANT

## Operation
- States: IDLE, GRANT. Encoding 1 bit.
- IDLE: gnt=0. If any req bit set, pick winner w = first requester with req set, scanning from rr_ptr upward modulo 3. Set gnt to one-hot w, clear burst_cnt, enter GRANT. If none, stay.
- GRANT: a pixel is accepted on every edge where req[w]=1. Accepted pixel: vga_x/y/colour <= requester w's fields, vga_plot<=1, burst_cnt+=1.
- Release: return to IDLE, gnt<=0, rr_ptr<=(w+1) mod 3 when any of:
  - accepted pixel has last[w]=1
  - accepted pixel brings burst_cnt to MAX_BURST
  - req[w]=0 (abort; no pixel written that cycle)
- Forced release at MAX_BURST does not drop the request. The requester keeps req high and re-arbitrates, but rr_ptr has moved past it.
- Inputs from non-granted requesters are ignored. last[i] without gnt[i] is ignored.
- vga_plot=0 on every edge without an accepted pixel. vga_x/y/colour hold their last value when plot=0.
- Reset values: state IDLE, gnt=0, rr_ptr=0, burst_cnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0.

## Timing
- Arbitration latency: req sampled high at edge k in IDLE gives gnt high after edge k.
- First pixel: accepted at edge k+1 if req still high, so vga_plot is high after edge k+1. One pixel per cycle thereafter.
- Turnaround: one dead IDLE cycle after every release. Back-to-back bursts from different requesters are separated by exactly one plot-free cycle, plus the grant cycle.
- Requester handshake: data on x_in/y_in/colour_in and last must be valid in every cycle where req[i]&gnt[i]=1. A requester advances its own data after each such edge.
- Simultaneous requests in IDLE: rr_ptr decides; with rr_ptr=0 the order is 0, then 1, then 2.
- Reset asserted mid-burst: next edge forces every reset value. Any pixel presented that cycle is not written.
- burst_cnt never exceeds MAX_BURST. No wrap.

## Structure
- Shared display package holds:
  - X_W/Y_W/C_W screen constants
  - requester index constants REQ_GRID=0, REQ_NOTE=1, REQ_FLASH=2
  - state encoding
- One combinational sub-module, rr_pick3. Inputs: req[2:0], ptr[1:0]. Outputs: winner index and a valid flag. Used in IDLE only.
- Remainder is a single always block for state, gnt, rr_ptr, burst_cnt and the output registers.

## Test plan
- Single requester: req[1]=1 for 4 pixels, last on the 4th. Expect:
  - gnt=3'b010 one cycle after req
  - 4 consecutive vga_plot pulses carrying requester 1's coordinates in order
  - gnt=0 after the 4th; rr_ptr=2
- All three req high from reset with last on the first pixel, held high throughout. Expect grants in order 0, 1, 2, 0, each plot separated by one dead cycle.
- MAX_BURST=160, requester 0 streams 200 pixels with no last, while requester 2 requests. Expect:
  - exactly 160 plots, then release
  - requester 2 granted next
  - requester 0 re-granted afterwards for the remaining 40
- Abort: requester 1 granted, drops req after 2 pixels with no last. Expect 2 plots, release next edge, no plot in the abort cycle.
- Ignore non-owner: requester 0 granted; toggle requester 2's x_in and last. Expect:
  - vga_x always follows requester 0
  - gnt unchanged until requester 0's last
- Reset mid-burst at pixel 3 of requester 2. Expect after that edge: gnt=0, vga_plot=0, vga_x=0, busy=0. Next arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// Shared display constants, requester indices and arbiter state encoding
// used by the VGA pixel-write arbiter and its helpers.
package vga_write_arbiter_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam logic [1:0] REQ_GRID  = 2'd0;
    localparam logic [1:0] REQ_NOTE  = 2'd1;
    localparam logic [1:0] REQ_FLASH = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

    // Requester index arithmetic modulo 3; idx is always 0..2 in practice.
    function automatic logic [1:0] wrapAdd(input logic [1:0] idx, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, idx} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    function automatic logic [1:0] nextReq(input logic [1:0] idx);
        return wrapAdd(idx, 2'd1);
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters: the first set
// request found scanning upward from ptr (modulo 3) wins.
module rr_pick3
    import vga_write_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] cand [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
        assign cand[gi] = wrapAdd(ptr, 2'(gi));
    end

    // Scan from the farthest candidate back so the nearest one to ptr wins.
    always_comb begin
        winner = ptr;
        valid  = |req;
        for (int k = 2; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin burst arbiter sharing the VGA adapter pixel-write port between
// the grid, note and flash drawing engines; pixels are registered to the adapter.
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int X_W       = vga_write_arbiter_pkg::X_W,
    parameter int Y_W       = vga_write_arbiter_pkg::Y_W,
    parameter int C_W       = vga_write_arbiter_pkg::C_W,
    parameter int BURST_W   = 8,
    parameter int MAX_BURST = 160
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         req,
    input  logic [2:0]         last,
    input  logic [3*X_W-1:0]   x_in,
    input  logic [3*Y_W-1:0]   y_in,
    input  logic [3*C_W-1:0]   colour_in,
    output logic [2:0]         gnt,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [C_W-1:0]     vga_colour,
    output logic               vga_plot,
    output logic               busy
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

    arbState_t          state;
    logic [1:0]         rrPtr;
    logic [1:0]         owner;
    logic [BURST_W-1:0] burstCnt;
    logic [BURST_W-1:0] burstInc;
    logic [1:0]         pickWinner;
    logic               pickValid;

    logic [X_W-1:0] xField [3];
    logic [Y_W-1:0] yField [3];
    logic [C_W-1:0] cField [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign xField[gi] = x_in[gi*X_W +: X_W];
        assign yField[gi] = y_in[gi*Y_W +: Y_W];
        assign cField[gi] = colour_in[gi*C_W +: C_W];
    end

    rr_pick3 u_pick (
        .req    (req),
        .ptr    (rrPtr),
        .winner (pickWinner),
        .valid  (pickValid)
    );

    assign burstInc = burstCnt + BURST_W'(1);
    assign busy     = (state == GRANT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rrPtr      <= REQ_GRID;
            owner      <= REQ_GRID;
            burstCnt   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        gnt      <= 3'b001 << pickWinner;
                        owner    <= pickWinner;
                        burstCnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[owner]) begin
                        vga_x      <= xField[owner];
                        vga_y      <= yField[owner];
                        vga_colour <= cField[owner];
                        vga_plot   <= 1'b1;
                        burstCnt   <= burstInc;
                    end
                    // Release on abort, end of burst, or the burst cap; the
                    // pointer moves past the owner so a capped engine waits its turn.
                    if (!req[owner] || last[owner] || (burstInc == MAX_CNT)) begin
                        state <= IDLE;
                        gnt   <= '0;
                        rrPtr <= nextReq(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: requester models drive bursts, expected
// pixels go into a scoreboard queue that a separate monitor checks on every plot.
module tb_vga_write_arbiter;
    import vga_write_arbiter_pkg::*;

    localparam int MAXB = 160;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pix_t;

    logic               clock = 1'b0;
    logic               reset;
    logic [2:0]         req;
    logic [2:0]         last;
    logic [3*X_W-1:0]   x_in;
    logic [3*Y_W-1:0]   y_in;
    logic [3*C_W-1:0]   colour_in;
    logic [2:0]         gnt;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [C_W-1:0]     vga_colour;
    logic               vga_plot;
    logic               busy;

    pix_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   plotNum    = 0;

    int   en[3];
    int   cnt[3];
    int   lastEvery[3];
    int   pos[3];
    bit   noise2;

    always #5 clock = ~clock;

    vga_write_arbiter #(
        .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .BURST_W(8), .MAX_BURST(MAXB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .last       (last),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .gnt        (gnt),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    function automatic pix_t pixOf(int i, int p);
        pix_t r;
        r.x = X_W'(i*64 + p);
        r.y = Y_W'(i*40 + p%40);
        r.c = C_W'(i + p);
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            pix_t p;
            logic act;
            p   = pixOf(i, pos[i]);
            act = (en[i] != 0) && (pos[i] < cnt[i]);
            req[i]                   = act;
            x_in[i*X_W +: X_W]       = p.x;
            y_in[i*Y_W +: Y_W]       = p.y;
            colour_in[i*C_W +: C_W]  = p.c;
            last[i] = act && (lastEvery[i] != 0) && (((pos[i] + 1) % lastEvery[i]) == 0);
        end
        if (noise2) begin
            x_in[2*X_W +: X_W] = X_W'($urandom);
            last[2]            = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: present data, then advance each requester whose pixel was taken.
    task automatic tick();
        logic [2:0] acc;
        drive();
        acc = req & gnt;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) pos[i]++;
        end
    endtask

    task automatic setReq(int i, int n, int le);
        en[i] = 1; cnt[i] = n; lastEvery[i] = le; pos[i] = 0;
    endtask

    task automatic clearAll();
        for (int i = 0; i < 3; i++) en[i] = 0;
        noise2 = 1'b0;
    endtask

    task automatic pushExp(int i, int from, int to);
        for (int p = from; p <= to; p++) expQ.push_back(pixOf(i, p));
    endtask

    task automatic drain(string name, int budget);
        int k;
        k = 0;
        while ((expQ.size() != 0 || busy || req != 3'b000) && k < budget) begin
            tick();
            k++;
        end
        check({name, "_drain_in_budget"}, 32'(k < budget), 32'd1);
    endtask

    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clock);
            if (vga_plot) begin
                compared++;
                plotNum++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot",
                             vga_x, vga_y, vga_colour);
                end else begin
                    e = expQ.pop_front();
                    if ({vga_x, vga_y, vga_colour} !== e) begin
                        mismatched++;
                        $display("FAIL plot_%0d: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                                 plotNum, vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                    end else begin
                        $display("plot %0d: x=%0d y=%0d c=%0d ok", plotNum, vga_x, vga_y, vga_colour);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [23:0] gseq;
        logic [7:0]  pseq;
        logic [11:0] gseqC;
        logic [2:0]  prevG;
        int          grantsC;
        bit          doneC;

        req = '0; last = '0; x_in = '0; y_in = '0; colour_in = '0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 0; cnt[i] = 0; lastEvery[i] = 0; pos[i] = 0;
        end
        noise2 = 1'b0;
        reset  = 1'b1;
        tick(); tick();
        check("reset_gnt",  32'(gnt),      32'd0);
        check("reset_plot", 32'(vga_plot), 32'd0);
        check("reset_x",    32'(vga_x),    32'd0);
        check("reset_busy", 32'(busy),     32'd0);
        reset = 1'b0;

        // Single requester 1, four pixels, last on the fourth.
        setReq(1, 4, 4);
        pushExp(1, 0, 3);
        tick();
        check("A_gnt", 32'(gnt), 32'b010);
        check("A_busy", 32'(busy), 32'd1);
        tick(); tick(); tick(); tick();
        check("A_release_gnt", 32'(gnt), 32'd0);
        // rr_ptr is now 2: with requesters 0 and 2 pending, 2 goes first.
        setReq(0, 1, 1);
        setReq(2, 1, 1);
        pushExp(2, 0, 0);
        pushExp(0, 0, 0);
        tick();
        check("A_ptr_gnt", 32'(gnt), 32'b100);
        drain("A", 20);

        // All three from reset, one pixel per burst: order 0,1,2,0.
        clearAll();
        reset = 1'b1;
        setReq(0, 2, 1); setReq(1, 1, 1); setReq(2, 1, 1);
        pushExp(0, 0, 0); pushExp(1, 0, 0); pushExp(2, 0, 0); pushExp(0, 1, 1);
        tick(); tick();
        reset = 1'b0;
        gseq = '0; pseq = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            gseq = {gseq[20:0], gnt};
            pseq = {pseq[6:0], vga_plot};
        end
        check("B_gnt_seq",  32'(gseq), 32'(24'b001_000_010_000_100_000_001_000));
        check("B_plot_seq", 32'(pseq), 32'(8'b0101_0101));
        drain("B", 10);

        // Requester 0 streams 200 with no last; requester 2 cuts in at the cap.
        clearAll();
        setReq(0, 200, 0);
        pushExp(0, 0, MAXB-1); pushExp(2, 0, 2); pushExp(0, MAXB, 199);
        prevG = '0; gseqC = '0; grantsC = 0; doneC = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k == 2) setReq(2, 3, 3);
            tick();
            if (gnt != 3'b000 && prevG == 3'b000) begin
                gseqC = {gseqC[8:0], gnt};
                grantsC++;
            end
            prevG = gnt;
            if (k > 2 && expQ.size() == 0 && !busy && req == 3'b000) begin
                doneC = 1'b1;
                break;
            end
        end
        check("C_done", 32'(doneC), 32'd1);
        check("C_grant_order", 32'(gseqC), 32'(12'b000_001_100_001));
        check("C_grant_count", 32'(grantsC), 32'd3);

        // Abort: requester 1 drops req after two pixels.
        clearAll();
        setReq(1, 2, 0);
        pushExp(1, 0, 1);
        tick();
        check("D_gnt", 32'(gnt), 32'b010);
        tick(); tick(); tick();
        check("D_abort_gnt",  32'(gnt),      32'd0);
        check("D_abort_plot", 32'(vga_plot), 32'd0);
        check("D_abort_busy", 32'(busy),     32'd0);

        // Requester 0 owns the port while requester 2 toggles x and last.
        clearAll();
        setReq(0, 5, 5);
        noise2 = 1'b1;
        pushExp(0, 0, 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("E_hold_gnt", 32'(gnt), 32'b001);
        end
        tick();
        check("E_release_gnt", 32'(gnt), 32'd0);
        noise2 = 1'b0;

        // Reset while requester 2 presents its third pixel (rr_ptr is 1 here).
        clearAll();
        setReq(2, 6, 0);
        pushExp(2, 0, 1);
        tick();
        check("F_gnt", 32'(gnt), 32'b100);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("F_reset_gnt",  32'(gnt),      32'd0);
        check("F_reset_plot", 32'(vga_plot), 32'd0);
        check("F_reset_x",    32'(vga_x),    32'd0);
        check("F_reset_busy", 32'(busy),     32'd0);
        reset = 1'b0;
        clearAll();
        setReq(0, 1, 1); setReq(1, 1, 1);
        pushExp(0, 0, 0); pushExp(1, 0, 0);
        tick();
        check("F_ptr_gnt", 32'(gnt), 32'b001);
        drain("F", 20);

        tick();
        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
